lfsr_count_sequencer: RTL and testbench
=======================================

// Module: lfsr_count_sequencer
// PURPOSE
//  Command-driven sequencer for the 8-bit LFSR/cascaded counter datapath.
//  Accepts a "run N ticks" command and optionally clears the counter first.
//  Drives the counter's count-enable for exactly N un-held cycles, then captures
//  the counter value and returns it on a valid/ready response channel.
//  Sits between a host/requester and the counter top.
// PARAMETERS
//  LEN_W   8   width of command tick length and of the internal remaining-tick counter
//  CNT_W   8   width of counter value observed and returned (counter Q bus)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command (IDLE only)
//  cmd_len    in   LEN_W  ticks to run (0 = snapshot only)
//  cmd_clr    in   1      reset the counter before running
//  cmd_cont   in   1      continuous mode: re-run same length after each response
//  hold       in   1      pause: suppresses cnt_en, remaining count frozen
//  stop       in   1      abort run / end continuous mode
//  cnt_q      in   CNT_W  counter value (counter Q output)
//  cnt_en     out  1      counter count enable
//  cnt_rst    out  1      counter sync reset = rst | (state==CLEAR)
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      response consumed
//  rsp_data   out  CNT_W  captured counter value
//  rsp_abort  out  1      run ended by stop before N ticks
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1 in the cycle after reset; cnt_en, rsp_valid, rsp_abort, busy = 0;
//   rsp_data=0, remaining=0, saved len/cont=0. cnt_rst=1 while rst is high.
//  FSM: IDLE, CLEAR, RUN, CAPTURE, RESP.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch len/cont; remaining<=cmd_len.
//   Next state: CLEAR if cmd_clr; else CAPTURE if cmd_len==0; else RUN.
//  CLEAR: exactly 1 cycle with cnt_rst=1, cnt_en=0. Next: RUN, or CAPTURE if len==0.
//  RUN: cnt_en = !hold && !stop (combinational from state). Each cycle with cnt_en=1
//   decrements remaining. If remaining==1 and cnt_en=1, next=CAPTURE. Hold freezes
//   remaining indefinitely. If stop=1, next=CAPTURE with abort flag set (stop beats hold).
//  CAPTURE: 1 cycle, cnt_en=0. Lets counter Q settle after the last enable edge.
//   rsp_data<=cnt_q; rsp_abort<=abort flag; next RESP with rsp_valid=1.
//  RESP: rsp_valid and rsp_data stay stable until rsp_ready.
//   On rsp_valid&rsp_ready: if cont && !abort && !stop, then remaining<=len and next RUN
//   (no clear; CAPTURE if len==0). Otherwise next IDLE and cont cleared.
//  Latency: non-clear command of N>=1 with no hold, rsp_ready=1 gives cnt_en high for
//   cycles 1..N after accept and rsp_valid in cycle N+2. Clear adds 1 cycle.
//  stop in IDLE/CLEAR/CAPTURE: no effect except that the captured response is flagged
//   abort when stop arrives during RUN. stop in RESP cancels continuous repeat only.
//  rst mid-operation: immediate return to reset values; a pending response is discarded.
//  remaining never underflows. len=0 never asserts cnt_en.
//  Exactly one cnt_en per decrement. Counter wrap-around is the datapath's concern;
//   rsp_data is the raw Q.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE..RESP), default LEN_W/CNT_W.
//  Sub-module lfsr_seq_tick_cnt: loadable down-counter (load, dec, is_one, is_zero).
//  Top: FSM + response register.
// TESTING
//  1 cmd len=5 clr=1, hold=0, rsp_ready=1 -> cnt_rst 1 cycle, cnt_en 5 cycles,
//    rsp_data == counter Q after 5 ticks from reset, abort=0.
//  2 len=0 clr=0 -> no cnt_en; rsp_valid 2 cycles after accept; rsp_data=current cnt_q.
//  3 len=4, hold high for 3 cycles after 2nd tick -> exactly 4 cnt_en pulses total;
//    rsp 3 cycles later than scenario w/o hold.
//  4 len=200, stop at tick 10 -> 10 cnt_en pulses, rsp_abort=1, back to IDLE.
//  5 cont=1 len=3, rsp_ready low 4 cycles -> rsp_data stable, cnt_en=0 while waiting.
//    3 ticks per repeat; stop in RESP -> IDLE after handshake.
//  6 rst asserted in RUN (remaining=7) -> next cycle IDLE, cnt_en=0, rsp_valid=0,
//    cmd_ready=1.

Source files
------------

// File: rtl/lfsr_count_sequencer_pkg.sv
// Shared types and defaults for the LFSR/counter command sequencer.
// State encoding plus default widths for the tick length and counter value.
package lfsr_count_sequencer_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_CLEAR   = S_CLEAR,
        ST_RUN     = S_RUN,
        ST_CAPTURE = S_CAPTURE,
        ST_RESP    = S_RESP
    } seq_state_t;

endpackage

// File: rtl/lfsr_seq_tick_cnt.sv
// Loadable down-counter holding the ticks still to run.
// Saturates at zero so a stray decrement can never wrap.
module lfsr_seq_tick_cnt
    import lfsr_count_sequencer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one,
    output logic             is_zero
);

    logic [LEN_W-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_val;
        end else if (dec && (rem != '0)) begin
            rem <= rem - 1'b1;
        end
    end

    assign is_one  = (rem == LEN_W'(1));
    assign is_zero = (rem == '0);

endmodule

// File: rtl/lfsr_count_sequencer.sv
// Command sequencer: runs the counter for N un-held ticks,
// then captures its value onto a valid/ready response channel.
module lfsr_count_sequencer
    import lfsr_count_sequencer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_clr,
    input  logic             cmd_cont,
    input  logic             hold,
    input  logic             stop,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_rst,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_data,
    output logic             rsp_abort,
    output logic             busy
);

    seq_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic             cont_q;
    logic             abort_q;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             repeat_go;
    logic             tick_load;
    logic [LEN_W-1:0] tick_val;
    logic             tick_one;
    logic             tick_zero;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign cnt_en    = (state == ST_RUN) && !hold && !stop;
    assign cnt_rst   = rst || (state == ST_CLEAR);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign repeat_go = cont_q && !abort_q && !stop;
    assign tick_load = cmd_fire || (rsp_fire && repeat_go);
    assign tick_val  = cmd_fire ? cmd_len : len_q;

    lfsr_seq_tick_cnt #(
        .LEN_W (LEN_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (tick_load),
        .load_val (tick_val),
        .dec      (cnt_en),
        .is_one   (tick_one),
        .is_zero  (tick_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            cont_q    <= 1'b0;
            abort_q   <= 1'b0;
            rsp_data  <= '0;
            rsp_abort <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_q   <= cmd_len;
                        cont_q  <= cmd_cont;
                        abort_q <= 1'b0;
                        unique case (1'b1)
                            cmd_clr:          state <= ST_CLEAR;
                            (cmd_len == '0):  state <= ST_CAPTURE;
                            default:          state <= ST_RUN;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    state <= tick_zero ? ST_CAPTURE : ST_RUN;
                end
                ST_RUN: begin
                    // stop wins over hold and over the final tick
                    if (stop) begin
                        abort_q <= 1'b1;
                        state   <= ST_CAPTURE;
                    end else if ((cnt_en && tick_one) || tick_zero) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data  <= cnt_q;
                    rsp_abort <= abort_q;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (repeat_go) begin
                            state <= (len_q == '0) ? ST_CAPTURE : ST_RUN;
                        end else begin
                            cont_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_count_sequencer.sv
// Bench for lfsr_count_sequencer with a behavioural counter datapath
// and a response scoreboard filled when each command is driven.
module tb_lfsr_count_sequencer;

    localparam int TMO = 400;

    typedef struct packed {
        logic [7:0] data;
        logic       abort;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_clr = 1'b0;
    logic       cmd_cont = 1'b0;
    logic       hold = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cnt_q = 8'd0;
    logic       cnt_en;
    logic       cnt_rst;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_abort;
    logic       busy;

    rsp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         en_pulses = 0;
    int         clr_pulses = 0;
    logic [7:0] mval = 8'd0;

    lfsr_count_sequencer #(
        .LEN_W (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_clr   (cmd_clr),
        .cmd_cont  (cmd_cont),
        .hold      (hold),
        .stop      (stop),
        .cnt_q     (cnt_q),
        .cnt_en    (cnt_en),
        .cnt_rst   (cnt_rst),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_abort (rsp_abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_rst) cnt_q <= 8'd0;
        else if (cnt_en) cnt_q <= cnt_q + 8'd1;
        if (cnt_en) en_pulses <= en_pulses + 1;
        if (cnt_rst && !rst) clr_pulses <= clr_pulses + 1;
    end

    task automatic run_cmd(
        input  logic [7:0] len,
        input  logic       clr,
        input  int         hs,
        input  int         hl,
        input  int         stopc,
        output int         lat,
        output int         en,
        output int         clrs
    );
        int e0;
        int c0;
        int n;
        @(negedge clk);
        e0 = en_pulses;
        c0 = clr_pulses;
        cmd_valid = 1'b1;
        cmd_len = len;
        cmd_clr = clr;
        cmd_cont = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        forever begin
            hold = (n >= hs) && (n < hs + hl);
            stop = (n == stopc);
            if (rsp_valid || n >= TMO) break;
            @(negedge clk);
            n++;
        end
        hold = 1'b0;
        stop = 1'b0;
        lat = rsp_valid ? n : -1;
        en = en_pulses - e0;
        clrs = clr_pulses - c0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cnt_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt_rst got=%b want=1", cnt_rst);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, cnt_en, rsp_valid, rsp_abort}
            !== 5'b10000 || rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%h want=10000/00",
                {cmd_ready, busy, cnt_en, rsp_valid, rsp_abort},
                rsp_data);
        end
    endtask

    task automatic test_clear_run();
        int lat, en, clrs;
        rsp_t ex;
        mval = 8'd5;
        sb.push_back('{mval, 1'b0});
        run_cmd(8'd5, 1'b1, 0, 0, 0, lat, en, clrs);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== 8 || en !== 5 || clrs !== 1) begin
            n_fail++;
            $display("FAIL clr_timing got=%0d/%0d/%0d want=8/5/1",
                lat, en, clrs);
        end
        n_checks++;
        if (rsp_data !== ex.data || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL clr_data got=%h/%b want=%h/%b",
                rsp_data, rsp_abort, ex.data, ex.abort);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_idle got=%b%b want=01",
                rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_snapshot();
        int lat, en, clrs;
        rsp_t ex;
        sb.push_back('{mval, 1'b0});
        run_cmd(8'd0, 1'b0, 0, 0, 0, lat, en, clrs);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== 2 || en !== 0 || clrs !== 0) begin
            n_fail++;
            $display("FAIL snap_timing got=%0d/%0d/%0d want=2/0/0",
                lat, en, clrs);
        end
        n_checks++;
        if (rsp_data !== ex.data || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL snap_data got=%h/%b want=%h/%b",
                rsp_data, rsp_abort, ex.data, ex.abort);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int lat, en, clrs;
        rsp_t ex;
        mval = mval + 8'd4;
        sb.push_back('{mval, 1'b0});
        run_cmd(8'd4, 1'b0, 3, 3, 0, lat, en, clrs);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== 9 || en !== 4) begin
            n_fail++;
            $display("FAIL hold_timing got=%0d/%0d want=9/4", lat, en);
        end
        n_checks++;
        if (rsp_data !== ex.data || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL hold_data got=%h/%b want=%h/%b",
                rsp_data, rsp_abort, ex.data, ex.abort);
        end
        @(negedge clk);
    endtask

    task automatic test_stop();
        int lat, en, clrs;
        rsp_t ex;
        mval = mval + 8'd10;
        sb.push_back('{mval, 1'b1});
        run_cmd(8'd200, 1'b0, 0, 0, 11, lat, en, clrs);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== 13 || en !== 10) begin
            n_fail++;
            $display("FAIL stop_timing got=%0d/%0d want=13/10", lat, en);
        end
        n_checks++;
        if (rsp_data !== ex.data || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL stop_data got=%h/%b want=%h/%b",
                rsp_data, rsp_abort, ex.data, ex.abort);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle got=%b%b want=10", cmd_ready, busy);
        end
    endtask

    task automatic test_continuous();
        int e0;
        int n;
        rsp_t ex;
        @(negedge clk);
        rsp_ready = 1'b0;
        e0 = en_pulses;
        cmd_valid = 1'b1;
        cmd_len = 8'd3;
        cmd_clr = 1'b0;
        cmd_cont = 1'b1;
        mval = mval + 8'd3;
        sb.push_back('{mval, 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_cont = 1'b0;
        n = 1;
        while (!rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 5 || !rsp_valid) begin
            n_fail++;
            $display("FAIL cont_lat1 got=%0d want=5", n);
        end
        ex = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ex.data
                || cnt_en !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_wait%0d got=%b/%h/%b want=1/%h/0",
                    i, rsp_valid, rsp_data, cnt_en, ex.data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        n_checks++;
        if (en_pulses - e0 !== 3) begin
            n_fail++;
            $display("FAIL cont_en1 got=%0d want=3", en_pulses - e0);
        end
        mval = mval + 8'd3;
        sb.push_back('{mval, 1'b0});
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ex = sb.pop_front();
        n_checks++;
        if (n !== 5 || rsp_data !== ex.data || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL cont_rsp2 got=%0d/%h/%b want=5/%h/%b",
                n, rsp_data, rsp_abort, ex.data, ex.abort);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop got=%b%b%b want=100",
                cmd_ready, busy, rsp_valid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (en_pulses - e0 !== 6 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_en_total got=%0d want=6", en_pulses - e0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, en, clrs;
        rsp_t ex;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len = 8'd10;
        cmd_clr = 1'b0;
        sb.push_back('{8'hxx, 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || cnt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run got=%b%b want=11", busy, cnt_en);
        end
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, cnt_en, rsp_valid, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_rst got=%b want=1000",
                {cmd_ready, cnt_en, rsp_valid, busy});
        end
        rst = 1'b0;
        mval = 8'd2;
        sb.push_back('{mval, 1'b0});
        run_cmd(8'd2, 1'b0, 0, 0, 0, lat, en, clrs);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== 4 || en !== 2 || rsp_data !== ex.data
            || rsp_abort !== ex.abort) begin
            n_fail++;
            $display("FAIL mid_after got=%0d/%0d/%h/%b want=4/2/%h/%b",
                lat, en, rsp_data, rsp_abort, ex.data, ex.abort);
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_empty got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_clear_run();
        test_snapshot();
        test_hold();
        test_stop();
        test_continuous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
